// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: sequences a DIM x DIM systolic MAC array through read, skewed feed, drain and result hold
module systolic_seq_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DIM        = 4,
    parameter int MAX_K      = 16,
    parameter int K_WIDTH    = 5,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [K_WIDTH-1:0]        k_len_i,
    input  logic                      mode_bit_i,
    input  logic                      abort_i,
    output logic                      rd_en_o,
    output logic [ADDR_WIDTH-1:0]     rd_addr_o,
    input  logic [DIM*DATA_WIDTH-1:0] rd_a_data_i,
    input  logic [DIM*DATA_WIDTH-1:0] rd_b_data_i,
    output logic [DIM*DATA_WIDTH-1:0] a_feed_o,
    output logic [DIM*DATA_WIDTH-1:0] b_feed_o,
    output logic                      pe_start_o,
    output logic                      pe_mode_o,
    input  logic [DIM*DIM-1:0]        pe_ovf_i,
    output logic                      busy_o,
    output logic                      done_o,
    input  logic                      result_ack_i,
    output logic                      ovf_o
);
    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, k_q;
    logic [K_WIDTH-1:0]   k_clamp;
    logic                 mode_q, ovf_q, rd_v_q, accept, flush;
    assign accept      = cmd_valid_i && state_q == IDLE;
    assign flush       = abort_i && state_q != IDLE;
    assign k_clamp     = k_len_i > K_WIDTH'(MAX_K) ? K_WIDTH'(MAX_K) : k_len_i;
    assign cmd_ready_o = state_q == IDLE;
    assign busy_o      = state_q != IDLE;
    assign rd_en_o     = state_q == FEED;
    assign rd_addr_o   = rd_en_o ? cnt_q[ADDR_WIDTH-1:0] : '0;
    assign pe_start_o  = busy_o;
    assign pe_mode_o   = busy_o && mode_q;
    assign done_o      = state_q == DONE;
    assign ovf_o       = ovf_q;
    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end
    // Next state: drain ends on the last accumulate of the far-corner PE; abort beats everything
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = !cmd_valid_i ? IDLE : k_clamp == '0 ? DRAIN : FEED;
            FEED:    state_d = cnt_q == k_q - CNT_WIDTH'(1) ? DRAIN : FEED;
            DRAIN:   state_d = (k_q == '0 || cnt_q == k_q + CNT_WIDTH'(2*DIM-2)) ? DONE : DRAIN;
            DONE:    state_d = result_ack_i ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end
    // Command latches, cycle counter, sticky overflow and read-data valid flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            k_q    <= '0;
            mode_q <= 1'b0;
            ovf_q  <= 1'b0;
            rd_v_q <= 1'b0;
        end else begin
            cnt_q  <= accept ? '0 : (state_q == FEED || state_q == DRAIN) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
            k_q    <= accept ? CNT_WIDTH'(k_clamp) : k_q;
            mode_q <= accept ? mode_bit_i : mode_q;
            ovf_q  <= accept ? 1'b0 : busy_o ? ovf_q | (|pe_ovf_i) : ovf_q;
            rd_v_q <= rd_en_o && !flush;
        end
    end
    for (genvar g = 0; g < DIM; g++) begin : g_lane
        logic [DATA_WIDTH-1:0] a_in, b_in;
        assign a_in = rd_v_q ? rd_a_data_i[g*DATA_WIDTH +: DATA_WIDTH] : '0;
        assign b_in = rd_v_q ? rd_b_data_i[g*DATA_WIDTH +: DATA_WIDTH] : '0;
        if (g == 0) begin : g_direct
            assign a_feed_o[g*DATA_WIDTH +: DATA_WIDTH] = a_in;
            assign b_feed_o[g*DATA_WIDTH +: DATA_WIDTH] = b_in;
        end else begin : g_skew
            logic [DATA_WIDTH-1:0] a_sr [g];
            logic [DATA_WIDTH-1:0] b_sr [g];
            // Lane g is delayed g cycles so the wavefront enters the array diagonally
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni || flush) begin
                    for (int d = 0; d < g; d++) begin
                        a_sr[d] <= '0;
                        b_sr[d] <= '0;
                    end
                end else begin
                    a_sr[0] <= a_in;
                    b_sr[0] <= b_in;
                    for (int d = 1; d < g; d++) begin
                        a_sr[d] <= a_sr[d-1];
                        b_sr[d] <= b_sr[d-1];
                    end
                end
            end
            assign a_feed_o[g*DATA_WIDTH +: DATA_WIDTH] = a_sr[g-1];
            assign b_feed_o[g*DATA_WIDTH +: DATA_WIDTH] = b_sr[g-1];
        end
    end
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl: directed self-checking bench for the systolic sequencer with a behavioural PE array
module tb_systolic_seq_ctrl;
    localparam int DW = 8, DIM = 4, MAXK = 16;
    logic              clk_i = 0, rst_ni = 0, cmd_valid_i = 0, mode_bit_i = 0, abort_i = 0, result_ack_i = 0;
    logic [4:0]        k_len_i = '0;
    logic              cmd_ready_o, rd_en_o, pe_start_o, pe_mode_o, busy_o, done_o, ovf_o;
    logic [3:0]        rd_addr_o;
    logic [DIM*DW-1:0] rd_a_data_i, rd_b_data_i, a_feed_o, b_feed_o;
    logic [DIM*DIM-1:0] pe_ovf_i;
    int n_checks = 0, n_errors = 0;
    logic signed [DW-1:0] ma [DIM][MAXK];
    logic signed [DW-1:0] mb [MAXK][DIM];
    logic signed [DW-1:0] pa [DIM][DIM];
    logic signed [DW-1:0] pb [DIM][DIM];
    int acc [DIM][DIM];
    logic [DIM*DW-1:0] a_log [32];
    logic [DIM*DW-1:0] b_log [32];

    systolic_seq_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .k_len_i(k_len_i), .mode_bit_i(mode_bit_i), .abort_i(abort_i), .rd_en_o(rd_en_o),
        .rd_addr_o(rd_addr_o), .rd_a_data_i(rd_a_data_i), .rd_b_data_i(rd_b_data_i),
        .a_feed_o(a_feed_o), .b_feed_o(b_feed_o), .pe_start_o(pe_start_o), .pe_mode_o(pe_mode_o),
        .pe_ovf_i(pe_ovf_i), .busy_o(busy_o), .done_o(done_o), .result_ack_i(result_ack_i), .ovf_o(ovf_o)
    );

    always #5 clk_i = ~clk_i;

    // Operand memory: one-cycle read latency, garbage when not reading
    always @(posedge clk_i)
        for (int i = 0; i < DIM; i++) begin
            rd_a_data_i[i*DW +: DW] <= rd_en_o ? ma[i][rd_addr_o] : 8'h5A;
            rd_b_data_i[i*DW +: DW] <= rd_en_o ? mb[rd_addr_o][i] : 8'hA5;
        end

    // Output-stationary PE array: a flows right, b flows down, start low clears
    always @(posedge clk_i)
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                logic signed [DW-1:0] ai, bi;
                ai = (j == 0) ? signed'(a_feed_o[i*DW +: DW]) : pa[i][j-1];
                bi = (i == 0) ? signed'(b_feed_o[j*DW +: DW]) : pb[i-1][j];
                pa[i][j]  <= pe_start_o ? ai : '0;
                pb[i][j]  <= pe_start_o ? bi : '0;
                acc[i][j] <= pe_start_o ? acc[i][j] + int'(ai) * int'(bi) : 0;
            end

    // Per-PE overflow of a 16-bit signed accumulator
    always_comb begin
        pe_ovf_i = '0;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++)
                pe_ovf_i[i*DIM+j] = acc[i][j] > 32767 || acc[i][j] < -32768;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [DIM*DW-1:0] exp_a(input int c, input int k);
        logic [DIM*DW-1:0] v = '0;
        for (int i = 0; i < DIM; i++)
            if (c-1-i >= 0 && c-1-i < k) v[i*DW +: DW] = ma[i][c-1-i];
        return v;
    endfunction

    function automatic logic [DIM*DW-1:0] exp_b(input int c, input int k);
        logic [DIM*DW-1:0] v = '0;
        for (int j = 0; j < DIM; j++)
            if (c-1-j >= 0 && c-1-j < k) v[j*DW +: DW] = mb[c-1-j][j];
        return v;
    endfunction

    task automatic fill(input int kind);
        for (int i = 0; i < DIM; i++)
            for (int k = 0; k < MAXK; k++) begin
                ma[i][k] = kind == 0 ? DW'(i == k) : kind == 1 ? DW'(16*i+k+1) : 8'sd127;
                mb[k][i] = kind == 2 ? 8'sd127 : DW'(k*4+i+1);
            end
    endtask

    task automatic run_cmd(input int k, input logic mode);
        int last;
        last = k == 0 ? 1 : k + 2*DIM - 1;
        k_len_i = 5'(k);
        mode_bit_i = mode;
        cmd_valid_i = 1;
        step();
        cmd_valid_i = 0;
        for (int c = 0; c <= last; c++) begin
            check($sformatf("rd_en c%0d", c), rd_en_o, c < k);
            if (c < k) check($sformatf("rd_addr c%0d", c), rd_addr_o, c);
            check($sformatf("pe_start c%0d", c), pe_start_o, 1);
            check($sformatf("pe_mode c%0d", c), pe_mode_o, mode);
            check($sformatf("busy c%0d", c), busy_o, 1);
            check($sformatf("cmd_ready c%0d", c), cmd_ready_o, 0);
            check($sformatf("done c%0d", c), done_o, c == last);
            check($sformatf("a_feed c%0d", c), a_feed_o, exp_a(c, k));
            check($sformatf("b_feed c%0d", c), b_feed_o, exp_b(c, k));
            a_log[c] = a_feed_o;
            b_log[c] = b_feed_o;
            if (c < last) step();
        end
    endtask

    task automatic ack();
        result_ack_i = 1;
        step();
        result_ack_i = 0;
        check("ack done", done_o, 0);
        check("ack pe_start", pe_start_o, 0);
        check("ack cmd_ready", cmd_ready_o, 1);
        check("ack busy", busy_o, 0);
    endtask

    task automatic idle_outputs(input string tag);
        check({tag, " cmd_ready"}, cmd_ready_o, 1);
        check({tag, " busy"}, busy_o, 0);
        check({tag, " pe_start"}, pe_start_o, 0);
        check({tag, " rd_en"}, rd_en_o, 0);
        check({tag, " done"}, done_o, 0);
        check({tag, " a_feed"}, a_feed_o, 0);
        check({tag, " b_feed"}, b_feed_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        fill(0);
        step();
        step();
        idle_outputs("reset");
        check("reset ovf", ovf_o, 0);
        check("reset pe_mode", pe_mode_o, 0);
        rst_ni = 1;
        step();
        // Identity A, K=4: done at cycle 11, array holds B
        run_cmd(4, 0);
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++)
                check($sformatf("ident acc%0d%0d", i, j), acc[i][j], mb[i][j]);
        check("ident ovf", ovf_o, 0);
        ack();
        // Skew, K=2
        fill(1);
        run_cmd(2, 0);
        check("skew a2 c3", a_log[3][2*DW +: DW], 8'h21);
        check("skew a2 c4", a_log[4][2*DW +: DW], 8'h22);
        check("skew a2 c5", a_log[5][2*DW +: DW], 8'h00);
        check("skew b3 c4", b_log[4][3*DW +: DW], 8'h04);
        ack();
        // Overflow, then abort with ack in DONE keeps ovf
        fill(2);
        run_cmd(4, 0);
        check("ovf set", ovf_o, 1);
        check("ovf acc00", acc[0][0], 64516);
        abort_i = 1;
        result_ack_i = 1;
        step();
        abort_i = 0;
        result_ack_i = 0;
        idle_outputs("done abort");
        check("ovf retained", ovf_o, 1);
        fill(0);
        run_cmd(1, 0);
        check("ovf cleared", ovf_o, 0);
        ack();
        // Zero length, mode=1
        run_cmd(0, 1);
        ack();
        // Abort at cycle 3 of K=8, with an ignored command pulse at cycle 2
        fill(1);
        k_len_i = 5'd8;
        mode_bit_i = 0;
        cmd_valid_i = 1;
        step();
        cmd_valid_i = 0;
        step();
        step();
        cmd_valid_i = 1;
        k_len_i = 5'd1;
        step();
        cmd_valid_i = 0;
        check("abort pre rd_en", rd_en_o, 1);
        check("abort pre rd_addr", rd_addr_o, 3);
        abort_i = 1;
        step();
        abort_i = 0;
        idle_outputs("abort c4");
        step();
        idle_outputs("abort c5");
        // Async reset in DRAIN, then K=1 finishes at cycle 8
        k_len_i = 5'd4;
        cmd_valid_i = 1;
        step();
        cmd_valid_i = 0;
        repeat (6) step();
        check("drain busy", busy_o, 1);
        check("drain rd_en", rd_en_o, 0);
        #2;
        rst_ni = 0;
        #1;
        idle_outputs("async rst");
        check("async rst ovf", ovf_o, 0);
        step();
        rst_ni = 1;
        step();
        run_cmd(1, 0);
        ack();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
